// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_sequencer
//  Brief    : Program-counter owner and single-outstanding instruction fetch
//             sequencer with redirect/kill handling and a one-entry buffer.
//  Revision : 1.0
// ============================================================================
module pc_fetch_sequencer #(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_addr,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic               misalign_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 kill_q, kill_d;
    logic                 valid_q, valid_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      ipc_q, ipc_d;
    logic                 fault_q, fault_d;

    logic                 w_redir_ok;
    logic                 w_redir_bad;

    // A misaligned redirect only raises the fault; sequencing carries on as if absent.
    assign w_redir_ok  = redirect_valid & (redirect_addr[1:0] == 2'b00);
    assign w_redir_bad = redirect_valid & (redirect_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        fault_d = fault_q | w_redir_bad;

        case (state_q)
            S_IDLE: begin
                if (w_redir_ok) begin
                    pc_d = redirect_addr;
                end else if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (w_redir_ok) begin
                    pc_d = redirect_addr;
                    // An accepted request still returns a word, which must be dropped.
                    if (imem_ready) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redir_ok) begin
                    pc_d = redirect_addr;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_W'(4);
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redir_ok) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_addr;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
        end
    end

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign pc_out         = pc_q;
    assign instr_valid    = valid_q;
    assign instr          = instr_q;
    assign instr_pc       = ipc_q;
    assign misalign_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_sequencer
//  Brief    : Directed bench with a queue scoreboard and a latency-programmable
//             instruction-memory model for pc_fetch_sequencer.
//  Revision : 1.0
// ============================================================================
module tb_pc_fetch_sequencer;

    localparam int C_PC_W    = 10;
    localparam int C_INSTR_W = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   redirect_valid;
    logic [C_PC_W-1:0]      redirect_addr;
    logic                   imem_req;
    logic [C_PC_W-1:0]      imem_addr;
    logic                   imem_ready;
    logic                   imem_rvalid;
    logic [C_INSTR_W-1:0]   imem_rdata;
    logic                   instr_valid;
    logic [C_INSTR_W-1:0]   instr;
    logic [C_PC_W-1:0]      instr_pc;
    logic                   instr_ready;
    logic [C_PC_W-1:0]      pc_out;
    logic                   misalign_fault;

    pc_fetch_sequencer #(
        .PC_W     (C_PC_W),
        .INSTR_W  (C_INSTR_W),
        .RESET_PC ('0)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .pc_out         (pc_out),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C_PC_W-1:0]    pc;
        logic [C_INSTR_W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   xfer_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int                   mem_lat   = 1;
    bit                   use_fixed = 1'b0;
    logic [C_INSTR_W-1:0] fixed_word = 32'hDEADBEEF;

    function automatic logic [C_INSTR_W-1:0] word_of(input logic [C_PC_W-1:0] a);
        return 32'hA5C0_0000 | {22'd0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [C_PC_W-1:0] a);
        exp_t e;
        e.pc   = a;
        e.data = word_of(a);
        sb_q.push_back(e);
    endtask

    // Run until every expected transfer is consumed and the sequencer is requesting again.
    task automatic park(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (sb_q.size() == 0 && imem_req) begin
                done = 1'b1;
                break;
            end
        end
        imem_ready = 1'b0;
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},       32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid},    32'd0);
        chk({tag, "_instr"}, instr,                   32'd0);
        chk({tag, "_ipc"},   {22'd0, instr_pc},       32'd0);
        chk({tag, "_pc"},    {22'd0, pc_out},         32'd0);
        chk({tag, "_fault"}, {31'd0, misalign_fault}, 32'd0);
    endtask

    always @(posedge clk) cyc++;

    // Memory model: one outstanding request, response after mem_lat cycles.
    int                   pend_cnt  = 0;
    bit                   pend      = 1'b0;
    logic [C_INSTR_W-1:0] pend_data = '0;
    always begin
        bit                acc;
        logic [C_PC_W-1:0] a;
        @(posedge clk);
        acc = imem_req & imem_ready;
        a   = imem_addr;
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_data = use_fixed ? fixed_word : word_of(a);
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
                pend        = 1'b0;
            end
        end
    end

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_xfer_pc", {22'd0, instr_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_instr", instr, e.data);
                chk("sb_instr_pc", {22'd0, instr_pc}, {22'd0, e.pc});
                xfer_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        bit rose;
        int waited;
        reset          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;

        step(3);
        rst_chk("reset");
        reset = 1'b1;
        step(1);

        // Back-to-back fetch: 0x000, 0x004, 0x008 at one per three cycles.
        instr_ready = 1'b1;
        imem_ready  = 1'b1;
        push_exp(10'h000);
        push_exp(10'h004);
        push_exp(10'h008);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_req", {31'd0, imem_req}, 32'd1);
        park("seq_done");
        if (xfer_cyc.size() >= 3) begin
            chk("rate_0_1", xfer_cyc[1] - xfer_cyc[0], 32'd3);
            chk("rate_1_2", xfer_cyc[2] - xfer_cyc[1], 32'd3);
        end else begin
            chk("xfer_count", xfer_cyc.size(), 32'd3);
        end

        // Memory stall: request and address held for four cycles.
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", {22'd0, imem_addr}, 32'h00C);
        end
        push_exp(10'h00C);
        imem_ready = 1'b1;
        park("stall_done");

        // Redirect in WAIT: in-flight 0xDEADBEEF dropped, refetch from 0x040.
        mem_lat    = 3;
        use_fixed  = 1'b1;
        imem_ready = 1'b1;
        step(1);
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 10'h040;
        step(1);
        redirect_valid = 1'b0;
        rose   = 1'b0;
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            chk("kill_no_valid", {31'd0, instr_valid}, 32'd0);
            if (imem_req) begin
                rose = 1'b1;
                break;
            end
            step(1);
            waited++;
        end
        chk("kill_req_rose", {31'd0, rose}, 32'd1);
        chk("kill_req_delay", waited, 32'd2);
        chk("kill_new_addr", {22'd0, imem_addr}, 32'h040);
        use_fixed = 1'b0;
        mem_lat   = 1;
        push_exp(10'h040);
        imem_ready = 1'b1;
        park("redir_wait_done");

        // Redirect in HOLD with decode stalled.
        instr_ready = 1'b0;
        imem_ready  = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (instr_valid) begin
                rose = 1'b1;
                break;
            end
        end
        chk("hold_reached", {31'd0, rose}, 32'd1);
        chk("hold_ipc", {22'd0, instr_pc}, 32'h044);
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 10'h100;
        step(1);
        redirect_valid = 1'b0;
        chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
        chk("hold_redir_addr", {22'd0, imem_addr}, 32'h100);
        instr_ready = 1'b1;
        push_exp(10'h100);
        imem_ready = 1'b1;
        park("redir_hold_done");

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_addr  = 10'h3FC;
        step(1);
        redirect_valid = 1'b0;
        chk("req_redir_addr", {22'd0, imem_addr}, 32'h3FC);
        push_exp(10'h3FC);
        imem_ready = 1'b1;
        park("wrap_done");
        chk("wrap_addr", {22'd0, imem_addr}, 32'h000);

        // Misaligned redirect: sticky fault, PC untouched.
        redirect_valid = 1'b1;
        redirect_addr  = 10'h082;
        step(1);
        redirect_valid = 1'b0;
        chk("misalign_fault", {31'd0, misalign_fault}, 32'd1);
        chk("misalign_addr", {22'd0, imem_addr}, 32'h000);
        chk("misalign_req", {31'd0, imem_req}, 32'd1);
        step(3);
        chk("misalign_sticky", {31'd0, misalign_fault}, 32'd1);
        chk("misalign_pc_held", {22'd0, pc_out}, 32'h000);

        // Reset while WAITing; the late response must be ignored.
        mem_lat    = 3;
        imem_ready = 1'b1;
        step(1);
        imem_ready = 1'b0;
        reset = 1'b0;
        #1;
        rst_chk("async_rst");
        step(1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            rst_chk("late_rvalid");
        end
        mem_lat = 1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", {22'd0, imem_addr}, 32'h000);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch controller that owns the program counter and sequences instruction fetch. It issues one instruction-memory request at a time and registers each returned word with its PC into a one-entry output buffer for decode. It also applies jump/branch redirects, discarding any fetch already in flight. It sits between the register-file/decode stage and instruction memory and replaces the free-running PC incrementer.

## Interface
- PC_W, 10, PC / address width in bits (byte address).
- INSTR_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  single-cycle pulse; begins fetching from the current PC
- redirect_valid  in  1  jump/branch taken this cycle
- redirect_addr  in  PC_W  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_W  fetch address (= pc_out while imem_req=1)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response word valid (arrives ≥1 cycle after acceptance)
- imem_rdata  in  INSTR_W  response word
- instr_valid  out  1  output buffer holds an instruction
- instr  out  INSTR_W  fetched instruction
- instr_pc  out  PC_W  address of instr
- instr_ready  in  1  decode consumes instr (transfer = instr_valid & instr_ready)
- pc_out  out  PC_W  current fetch PC
- misalign_fault  out  1  sticky: a misaligned redirect was seen

## Operation
- Registers:
  - state (IDLE, REQ, WAIT, HOLD)
  - pc
  - kill flag (in-flight response must be dropped)
  - instr, instr_pc, instr_valid
  - misalign_fault
- Outputs: imem_req = (state==REQ); imem_addr = pc_out = pc. All other outputs are registered.
- IDLE:
  - start → REQ.
  - Redirect loads pc and stays IDLE.
- REQ:
  - imem_ready → WAIT.
  - Otherwise hold the request; address must stay stable.
- WAIT, on imem_rvalid:
  - kill=0: instr←imem_rdata, instr_pc←pc, instr_valid←1, pc←pc+4, → HOLD.
  - kill=1: kill←0, response discarded, → REQ.
- HOLD:
  - instr_ready → instr_valid←0, → REQ.
- Redirect (aligned, redirect_addr[1:0]==0) has priority over all other transitions and never causes a duplicate or stale transfer:
  - IDLE: pc←redirect_addr, stay IDLE.
  - REQ, imem_ready=0: pc←redirect_addr, stay REQ (new address next cycle).
  - REQ, imem_ready=1: request is accepted for the old address; pc←redirect_addr, kill←1, → WAIT.
  - WAIT: pc←redirect_addr; kill←1 unless imem_rvalid is high this cycle. If imem_rvalid is high, drop that word and → REQ.
  - HOLD: instr_valid←0 (a same-cycle instr_ready still counts as a transfer), pc←redirect_addr, → REQ.
- Misaligned redirect: misalign_fault←1. The redirect is otherwise ignored and state, pc and kill are unchanged. The fault clears only on reset.
- Arithmetic: pc+4 is modulo 2^PC_W; 0x3FC wraps to 0x000 silently.
- start outside IDLE is ignored. imem_rvalid outside WAIT is ignored.

## Timing
- Reset values (asynchronous, on reset=0):
  - state=IDLE, pc=RESET_PC, kill=0
  - instr_valid=0, instr=0, instr_pc=0, misalign_fault=0
  - imem_req=0
- Reset mid-operation aborts any in-flight fetch. A response arriving after reset release while in IDLE is ignored.
- start at edge N → imem_req=1 during cycle N+1.
- imem_ready with zero wait → WAIT next cycle. rvalid at edge M → instr_valid=1 from M+1.
- Minimum cycle per instruction is 3 cycles: REQ, WAIT, HOLD each one cycle.
- After a HOLD transfer, imem_req rises on the next cycle.
- Redirect at edge R → imem_addr=redirect_addr from R+1 when not killing. When killing, it appears one cycle after the killed response.
- At most one request is outstanding at any time.

## Test plan
- Reset release, start, memory always ready, rvalid one cycle after accept, instr_ready=1 → instr_pc sequence 0x000, 0x004, 0x008, one instruction every 3 cycles, instr matches rdata.
- imem_ready held low 4 cycles in REQ → imem_req and imem_addr stable the whole time. No state change until accept.
- Redirect to 0x040 in WAIT, rvalid two cycles later with 0xDEADBEEF → word dropped, instr_valid never rises for it, next request address 0x040.
- Redirect to 0x100 in HOLD with instr_ready=0 → instr_valid falls next cycle, next imem_addr=0x100, following instr_pc=0x100.
- PC at 0x3FC fetched → next fetch address 0x000. Redirect_addr=0x082 → misalign_fault=1 and sticky, pc unchanged.
- reset asserted while in WAIT, released, late rvalid arrives → ignored, outputs stay at reset values until start.
